mod60_down_timer: RTL
=====================

# mod60_down_timer

Synchronous two-digit BCD countdown timer (seconds field, 59 down to 00) built from a mod-10 ones digit and a mod-6 tens digit. It is the down-counting counterpart of the lab's mod-6 ripple up-counter. All flops share one clock; the ones digit borrows into the tens digit instead of rippling. The outputs drive the seven-segment display path and raise a one-cycle `done` pulse when the count expires.

## Interface
- `TICK_DIV`, default 1: clock cycles per count step (prescaler modulus), ≥1; 1 means step every cycle in RUN.
- `clk`  in  1  single clock; all state updates on posedge.
- `clr`  in  1  asynchronous, active-low reset.
- `load`  in  1  synchronous preset strobe.
- `ld_tens`  in  3  preset tens digit.
- `ld_ones`  in  4  preset ones digit.
- `start`  in  1  begin or resume counting (level sampled each cycle).
- `pause`  in  1  suspend counting.
- `tens`  out  3  tens digit, 0–5.
- `ones`  out  4  ones digit, 0–9.
- `running`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse on expiry.

## Operation
- States: IDLE, RUN, HOLD, DONE.
- Reset (`clr`=0, immediate): IDLE; `tens`=0, `ones`=0, prescaler=0, `running`=0, `done`=0.
- Priority each cycle: `load` > `pause` > `start`.
- `load`:
  - Valid in any state; forces IDLE and prescaler=0.
  - Out-of-range presets saturate: `ld_ones`>9 loads 9; `ld_tens`>5 loads 5.
- IDLE/HOLD + `start` with count ≠ 00: go to RUN, prescaler=0.
- IDLE/HOLD + `start` with count = 00: ignored.
- RUN + `pause`: go to HOLD; digits and prescaler frozen.
- RUN prescaler: counts 0..TICK_DIV-1. At TICK_DIV-1 the prescaler wraps to 0 and a step occurs.
- Step:
  - `ones`>0: `ones`-1.
  - `ones`=0: `ones`=9 and `tens`-1 (borrow).
  - A step is never taken at 00.
- Step producing 00: next state DONE.
- DONE: lasts exactly one cycle, then unconditionally IDLE.
  - `start` and `pause` are ignored in DONE.
  - `load` in DONE is honoured.
- `running` = (state==RUN); `done` = (state==DONE). Both are registered-state decodes with no combinational path from inputs.

## Timing
- `start` sampled at edge k: `running`=1 after edge k.
- First step lands at edge k+TICK_DIV, then every TICK_DIV edges.
- Edge that writes 00: state becomes DONE, `running`=0, `done`=1 for one cycle. IDLE at the following edge.
- `load` at edge k: digits valid after edge k; `running`=0.
- `pause` at edge k in RUN: no step at edge k, even when the prescaler is at TICK_DIV-1.
  - Resume continues from prescaler 0, so a partial interval is discarded.
- `clr` asserted mid-count: outputs go to reset values without waiting for a clock edge.
- `clr` release: takes effect at the first clock edge after deassertion.
- Latency from `load` to display: one edge. No other input-to-output latency.

## Structure
- Package `timer_pkg`:
  - `state_t` enum (IDLE, RUN, HOLD, DONE).
  - Constants ONES_W=4, TENS_W=3, ONES_MOD=10, TENS_MOD=6.
- Sub-module `bcd_down_digit`:
  - Parameters: MODULUS, W.
  - Ports: clk, clr, ld, ld_val, en, q, borrow.
  - Behaviour: `borrow` = `en` & (`q`==0). On `en`, `q` wraps 0→MODULUS-1, otherwise decrements. `ld` has priority over `en`. Saturation to MODULUS-1 is done inside the digit.
  - Instantiated twice. The ones digit `en` = step. The tens digit `en` = ones `borrow`.
- Top level holds the FSM and the prescaler (width $clog2(TICK_DIV), minimum 1).

## Test plan
- Reset: hold `clr`=0 with random inputs → `tens`=0, `ones`=0, `running`=0, `done`=0; release, no `start` → values unchanged.
- Full run, TICK_DIV=1: load 5/9, start → sequence 59,58,…,50,49,…,01,00 on consecutive edges; `done`=1 exactly one cycle at 00; then IDLE and count stays 00.
- Prescale and pause, TICK_DIV=3:
  - Load 1/0, start → 09 appears 3 edges after start.
  - Pause one cycle before the next step → no step; value held 5 cycles.
  - Start → 08 three edges later.
- Priority and saturation:
  - Load 7/12 → display 5/9.
  - Assert `load`+`start` together → IDLE, count 59, `running`=0.
  - Assert `start`+`pause` in HOLD → remains HOLD.
- Start at 00 → ignored, `running` stays 0, no `done`.
- Async reset mid-count (at 34, TICK_DIV=1): drop `clr` between edges → outputs 0 immediately; after release, count does not resume without load/start.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and digit geometry for the mod-60 countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int ONES_W   = 4;
    localparam int TENS_W   = 3;
    localparam int ONES_MOD = 10;
    localparam int TENS_MOD = 6;

endpackage

// File: rtl/mod60_down_timer_if.sv
// Control/display bundle between the timer and its driver (panel logic or bench).
interface mod60_down_timer_if;
    import timer_pkg::*;

    logic              load;
    logic [TENS_W-1:0] ld_tens;
    logic [ONES_W-1:0] ld_ones;
    logic              start;
    logic              pause;
    logic [TENS_W-1:0] tens;
    logic [ONES_W-1:0] ones;
    logic              running;
    logic              done;

    modport master (
        output load, ld_tens, ld_ones, start, pause,
        input  tens, ones, running, done
    );

    modport slave (
        input  load, ld_tens, ld_ones, start, pause,
        output tens, ones, running, done
    );

endinterface

// File: rtl/mod60_down_timer_digit.sv
// One BCD down-counting digit with saturating preset and borrow-out.
module bcd_down_digit #(
    parameter int MODULUS = 10,
    parameter int W       = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         borrow
);

    localparam logic [W-1:0] TOP = W'(MODULUS - 1);

    // Borrow fires only on the step that wraps this digit from 0.
    assign borrow = en && (q == '0);

    // Preset (clamped to the top digit value) wins over a count step.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= '0;
        end else if (ld) begin
            q <= (ld_val > TOP) ? TOP : ld_val;
        end else if (en) begin
            q <= (q == '0) ? TOP : q - 1'b1;
        end
    end

endmodule

// File: rtl/mod60_down_timer.sv
// Two-digit BCD seconds countdown (59..00) with prescaler, pause/resume and expiry pulse.
module mod60_down_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic                     clk,
    input  logic                     clr,
    mod60_down_timer_if.slave        bus
);

    localparam int PSC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_DIV - 1);

    state_t            state;
    logic [PSC_W-1:0]  psc;
    logic              running_q;
    logic              done_q;
    logic [ONES_W-1:0] ones_q;
    logic [TENS_W-1:0] tens_q;
    logic              ones_borrow;
    logic              tens_borrow;
    logic              cnt_zero;
    logic              step;
    logic              last_step;

    assign cnt_zero  = (tens_q == '0) && (ones_q == '0);
    // A step needs RUN, an uncontested cycle, a full prescale interval and a nonzero count.
    assign step      = (state == RUN) && !bus.load && !bus.pause &&
                       (psc == PSC_LAST) && !cnt_zero;
    assign last_step = step && (tens_q == '0) && (ones_q == ONES_W'(1));

    bcd_down_digit #(.MODULUS(ONES_MOD), .W(ONES_W)) u_ones (
        .clk    (clk),
        .clr    (clr),
        .ld     (bus.load),
        .ld_val (bus.ld_ones),
        .en     (step),
        .q      (ones_q),
        .borrow (ones_borrow)
    );

    bcd_down_digit #(.MODULUS(TENS_MOD), .W(TENS_W)) u_tens (
        .clk    (clk),
        .clr    (clr),
        .ld     (bus.load),
        .ld_val (bus.ld_tens),
        .en     (ones_borrow),
        .q      (tens_q),
        .borrow (tens_borrow)
    );

    // Tens never borrows out: the FSM stops at 00 before it could wrap.
    logic unused_borrow;
    assign unused_borrow = tens_borrow;

    // Control FSM and prescaler; running/done are registered alongside the state.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            psc       <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (bus.load) begin
            state     <= IDLE;
            psc       <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    done_q <= 1'b0;
                    if (!bus.pause && bus.start && !cnt_zero) begin
                        state     <= RUN;
                        psc       <= '0;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        // Freeze digits and prescaler; resume restarts the interval.
                        state     <= HOLD;
                        running_q <= 1'b0;
                    end else if (psc == PSC_LAST) begin
                        psc <= '0;
                        if (last_step) begin
                            state     <= DONE;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end else begin
                        psc <= psc + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    psc       <= '0;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tens    = tens_q;
    assign bus.ones    = ones_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;

endmodule
